// File: rtl/dbus_dma_if.sv
// rtl/dbus_dma_if.sv - control and data-bus signal bundle for dbus_dma; checksum present under DBUS_DMA_CHECKSUM_EN
interface dbus_dma_if #(
    parameter int LEN_W = 16
);
    logic             start;
    logic             mode;
    logic [31:0]      src_addr;
    logic [31:0]      dst_addr;
    logic [LEN_W-1:0] len_words;
    logic [31:0]      fill_data;
    logic             busy;
    logic             done;
    logic [31:0]      daddr;
    logic [31:0]      drdata;
    logic [31:0]      dwdata;
    logic [3:0]       dwe;
`ifdef DBUS_DMA_CHECKSUM_EN
    logic [31:0]      checksum;

    modport master (
        input  start, mode, src_addr, dst_addr, len_words, fill_data, drdata,
        output busy, done, daddr, dwdata, dwe, checksum
    );
    modport slave (
        output start, mode, src_addr, dst_addr, len_words, fill_data, drdata,
        input  busy, done, daddr, dwdata, dwe, checksum
    );
`else
    modport master (
        input  start, mode, src_addr, dst_addr, len_words, fill_data, drdata,
        output busy, done, daddr, dwdata, dwe
    );
    modport slave (
        output start, mode, src_addr, dst_addr, len_words, fill_data, drdata,
        input  busy, done, daddr, dwdata, dwe
    );
`endif
endinterface

// File: rtl/dbus_dma.sv
// rtl/dbus_dma.sv - data-bus fill/copy DMA initiator driving the dmem port while busy
// Optional running sum of written words enabled by DBUS_DMA_CHECKSUM_EN.
module dbus_dma #(
    parameter int LEN_W = 16
) (
    input  logic       clk,
    input  logic       reset,
    dbus_dma_if.master bus
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t           state_q, state_d;
    logic [31:0]      src_q, src_d;
    logic [31:0]      dst_q, dst_d;
    logic [31:0]      buf_q, buf_d;
    logic [31:0]      pat_q, pat_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             mode_q, mode_d;
    logic [31:0]      wdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            buf_q   <= '0;
            pat_q   <= '0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            buf_q   <= buf_d;
            pat_q   <= pat_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
        end
    end

    assign wdata = mode_q ? buf_q : pat_q;

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        buf_d   = buf_q;
        pat_d   = pat_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.len_words != '0) begin
                        src_d   = bus.src_addr & 32'hFFFF_FFFC;
                        dst_d   = bus.dst_addr & 32'hFFFF_FFFC;
                        cnt_d   = bus.len_words;
                        mode_d  = bus.mode;
                        pat_d   = bus.fill_data;
                        state_d = bus.mode ? READ : WRITE;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            READ: begin
                buf_d   = bus.drdata;
                src_d   = src_q + 32'd4;
                state_d = WRITE;
            end
            WRITE: begin
                dst_d = dst_q + 32'd4;
                cnt_d = cnt_q - LEN_W'(1);
                // cnt_q==1 means this write is the last one
                if (cnt_q == LEN_W'(1)) begin
                    state_d = DONE;
                end else begin
                    state_d = mode_q ? READ : WRITE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.daddr  = '0;
        bus.dwdata = '0;
        bus.dwe    = 4'h0;
        bus.busy   = 1'b0;
        bus.done   = 1'b0;
        unique case (state_q)
            READ: begin
                bus.daddr = src_q;
                bus.busy  = 1'b1;
            end
            WRITE: begin
                bus.daddr  = dst_q;
                bus.dwdata = wdata;
                bus.dwe    = 4'hF;
                bus.busy   = 1'b1;
            end
            DONE:    bus.done = 1'b1;
            default: ;
        endcase
    end

`ifdef DBUS_DMA_CHECKSUM_EN
    logic [31:0] sum_q, sum_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    always_comb begin
        sum_d = sum_q;
        if (state_q == IDLE && bus.start) begin
            sum_d = '0;
        end else if (state_q == WRITE) begin
            sum_d = sum_q + wdata;
        end
    end

    assign bus.checksum = sum_q;
`endif
endmodule

// File: tb/tb_dbus_dma.sv
// tb/tb_dbus_dma.sv - scoreboard bench for dbus_dma with a word-array memory model
module tb_dbus_dma;
    localparam int LEN_W = 16;

    logic clk = 1'b0;
    logic reset;
    logic load;
    always #5 clk = ~clk;

    dbus_dma_if #(.LEN_W(LEN_W)) bus ();
    dbus_dma #(.LEN_W(LEN_W)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;
    typedef struct {
        int          cyc;
        int          busy;
        logic [31:0] sum;
    } dn_t;

    wr_t         exp_wr[$];
    dn_t         exp_dn[$];
    wr_t         mon_w;
    dn_t         mon_d;
    logic [31:0] mem[1024];
    logic [31:0] ref_mem[1024];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          busy_cnt = 0;
    bit          mon_ok;

    function automatic int idx(input logic [31:0] a);
        return int'(a[11:2]);
    endfunction

    assign bus.drdata = mem[bus.daddr[11:2]];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (load) begin
            mem <= ref_mem;
        end else if (bus.dwe == 4'hF) begin
            mem[bus.daddr[11:2]] <= bus.dwdata;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            busy_cnt = 0;
        end else begin
            if (bus.busy) busy_cnt++;
            if (bus.dwe != 4'h0) begin
                checks++;
                if (exp_wr.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: addr=%h data=%h dwe=%h cyc=%0d, required no write",
                             bus.daddr, bus.dwdata, bus.dwe, cyc);
                end else begin
                    mon_w = exp_wr.pop_front();
                    if (bus.dwe !== 4'hF || bus.daddr !== mon_w.addr || bus.dwdata !== mon_w.data || cyc != mon_w.cyc) begin
                        errors++;
                        $display("FAIL write: got dwe=%h addr=%h data=%h cyc=%0d, required dwe=f addr=%h data=%h cyc=%0d",
                                 bus.dwe, bus.daddr, bus.dwdata, cyc, mon_w.addr, mon_w.data, mon_w.cyc);
                    end
                end
            end
            if (bus.done) begin
                checks++;
                if (exp_dn.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done: cyc=%0d, required no done", cyc);
                end else begin
                    mon_d  = exp_dn.pop_front();
                    mon_ok = (cyc == mon_d.cyc) && (busy_cnt == mon_d.busy) && !bus.busy && (bus.dwe == 4'h0);
`ifdef DBUS_DMA_CHECKSUM_EN
                    mon_ok = mon_ok && (bus.checksum === mon_d.sum);
                    if (!mon_ok) begin
                        errors++;
                        $display("FAIL done: got cyc=%0d busy_cycles=%0d busy=%b dwe=%h checksum=%h, required cyc=%0d busy_cycles=%0d busy=0 dwe=0 checksum=%h",
                                 cyc, busy_cnt, bus.busy, bus.dwe, bus.checksum, mon_d.cyc, mon_d.busy, mon_d.sum);
                    end
`else
                    if (!mon_ok) begin
                        errors++;
                        $display("FAIL done: got cyc=%0d busy_cycles=%0d busy=%b dwe=%h, required cyc=%0d busy_cycles=%0d busy=0 dwe=0",
                                 cyc, busy_cnt, bus.busy, bus.dwe, mon_d.cyc, mon_d.busy);
                    end
`endif
                end
                busy_cnt = 0;
            end
        end
    end

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    task automatic wait_drain(input int budget);
        int i = 0;
        while ((exp_dn.size() != 0 || exp_wr.size() != 0) && i < budget) begin
            @(negedge clk);
            i++;
        end
        checks++;
        if (exp_dn.size() != 0 || exp_wr.size() != 0) begin
            errors++;
            $display("FAIL timeout: %0d writes and %0d dones outstanding, required 0", exp_wr.size(), exp_dn.size());
            exp_wr.delete();
            exp_dn.delete();
        end
        @(negedge clk);
    endtask

    // Called at a negedge; the reference model applies the whole transfer word by word in ascending order.
    task automatic run_xfer(input logic m, input logic [31:0] s, input logic [31:0] d, input int n,
                            input logic [31:0] f, input bit poke);
        logic [31:0] sa, da, v, sum;
        int          c, lat;
        wr_t         w;
        dn_t         dn;
        sa  = s & 32'hFFFF_FFFC;
        da  = d & 32'hFFFF_FFFC;
        sum = '0;
        c   = cyc;
        lat = (n == 0) ? 0 : (m ? 2 * n : n);
        for (int k = 0; k < n; k++) begin
            v = m ? ref_mem[idx(sa + 32'(4 * k))] : f;
            ref_mem[idx(da + 32'(4 * k))] = v;
            w.addr = da + 32'(4 * k);
            w.data = v;
            w.cyc  = m ? c + 2 + 2 * k : c + 1 + k;
            exp_wr.push_back(w);
            sum += v;
        end
        dn.cyc  = c + 1 + lat;
        dn.busy = lat;
        dn.sum  = sum;
        exp_dn.push_back(dn);
        bus.start     = 1'b1;
        bus.mode      = m;
        bus.src_addr  = s;
        bus.dst_addr  = d;
        bus.len_words = LEN_W'(n);
        bus.fill_data = f;
        @(posedge clk);
        #1;
        bus.start     = 1'b0;
        bus.mode      = 1'($urandom);
        bus.src_addr  = $urandom;
        bus.dst_addr  = $urandom;
        bus.len_words = LEN_W'($urandom);
        bus.fill_data = $urandom;
        if (poke) begin
            @(negedge clk);
            @(negedge clk);
            bus.start     = 1'b1;
            bus.mode      = 1'b0;
            bus.dst_addr  = 32'h200;
            bus.len_words = LEN_W'(4);
            @(negedge clk);
            bus.start = 1'b0;
        end
        wait_drain(lat + 20);
    endtask

    task automatic run_abort();
        wr_t w;
        int  c;
        c = cyc;
        for (int k = 0; k < 2; k++) begin
            ref_mem[idx(32'h80 + 32'(4 * k))] = 32'h0BAD_F00D;
            w.addr = 32'h80 + 32'(4 * k);
            w.data = 32'h0BAD_F00D;
            w.cyc  = c + 1 + k;
            exp_wr.push_back(w);
        end
        bus.start     = 1'b1;
        bus.mode      = 1'b0;
        bus.dst_addr  = 32'h80;
        bus.len_words = LEN_W'(8);
        bus.fill_data = 32'h0BAD_F00D;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check32("abort_dwe", 32'(bus.dwe), 32'h0);
        check32("abort_busy", 32'(bus.busy), 32'h0);
        check32("abort_done", 32'(bus.done), 32'h0);
        check32("abort_daddr", bus.daddr, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (exp_wr.size() != 0) begin
            errors++;
            $display("FAIL abort_writes: %0d expected writes missing, required 0", exp_wr.size());
            exp_wr.delete();
        end
        repeat (12) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ref_mem[i] = $urandom;
        for (int i = 0; i < 4; i++) ref_mem[i] = 32'(i + 1);
        reset         = 1'b1;
        load          = 1'b1;
        bus.start     = 1'b0;
        bus.mode      = 1'b0;
        bus.src_addr  = '0;
        bus.dst_addr  = '0;
        bus.len_words = '0;
        bus.fill_data = '0;
        @(posedge clk);
        #1;
        load = 1'b0;
        #100;
        check32("reset_busy", 32'(bus.busy), 32'h0);
        check32("reset_done", 32'(bus.done), 32'h0);
        check32("reset_dwe", 32'(bus.dwe), 32'h0);
        check32("reset_daddr", bus.daddr, 32'h0);
        check32("reset_dwdata", bus.dwdata, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        run_xfer(1'b0, 32'h0, 32'h40, 4, 32'hDEAD_BEEF, 1'b0);
        for (int i = 16; i < 20; i++) check32("fill_word", mem[i], 32'hDEAD_BEEF);
        check32("fill_below", mem[15], ref_mem[15]);
        check32("fill_above", mem[20], ref_mem[20]);

        run_xfer(1'b1, 32'h0, 32'h100, 4, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++) check32("copy_word", mem[64 + i], 32'(i + 1));

        run_xfer(1'b0, 32'h0, 32'h500, 0, 32'h1234_5678, 1'b0);

        run_xfer(1'b0, 32'h0, 32'h300, 6, 32'hA5A5_5A5A, 1'b1);
        for (int i = 128; i < 132; i++) check32("ignored_start_region", mem[i], ref_mem[i]);

        run_abort();
        check32("abort_word32", mem[32], 32'h0BAD_F00D);
        check32("abort_word34", mem[34], ref_mem[34]);

        run_xfer(1'b0, 32'h0, 32'hFFFF_FFFA, 4, 32'h1357_9BDF, 1'b0);
        run_xfer(1'b1, 32'h403, 32'h408, 6, 32'h0, 1'b0);

        run_xfer(1'b0, 32'h0, 32'h600, 3, 32'h8000_0001, 1'b0);
`ifdef DBUS_DMA_CHECKSUM_EN
        check32("checksum_fill3", bus.checksum, 32'h8000_0003);
`endif

        for (int t = 0; t < 25; t++) begin
            run_xfer(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom_range(0, 12), $urandom, 1'b0);
        end

        for (int i = 0; i < 1024; i++) begin
            checks++;
            if (mem[i] !== ref_mem[i]) begin
                errors++;
                $display("FAIL mem_final[%0d]: got %h, required %h", i, mem[i], ref_mem[i]);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dbus_dma.md
Name: dbus_dma

Overview:
- Data-bus initiator that fills or copies word regions of data memory, using the same daddr/drdata/dwdata/dwe port the CPU drives into dmem.
- Sits beside the CPU. A top-level mux, outside this block, hands the dmem port to the DMA while busy=1.
- Used to preload or clear memory regions before a test and to move result blocks without CPU instructions.
- dmem is the responder: combinational read of drdata from daddr; byte-enabled write on posedge clk.

Parameters:
- LEN_W, 16, width of the word-count input; max transfer is 2^LEN_W-1 words.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request pulse; sampled only in IDLE.
- mode  in  1  0 = fill, 1 = copy; latched on start.
- src_addr  in  32  copy source byte address; bits[1:0] ignored (forced 0).
- dst_addr  in  32  destination byte address; bits[1:0] ignored (forced 0).
- len_words  in  LEN_W  number of 32-bit words to transfer.
- fill_data  in  32  fill pattern; latched on start.
- busy  out  1  high while a transfer occupies the bus.
- done  out  1  one-cycle pulse when a transfer completes.
- daddr  out  32  data-bus address.
- drdata  in  32  data-bus read data (combinational from dmem).
- dwdata  out  32  data-bus write data.
- dwe  out  4  byte write enables; 4'hF for a full-word write, 4'h0 otherwise.

Behaviour:
- States: IDLE, READ, WRITE, DONE.
- Registers: state, src ptr, dst ptr, remaining count, data buffer, latched mode and pattern.
- daddr, dwdata, dwe, busy and done decode from registered state only. No combinational path from any input to any output.
- Reset (async): state=IDLE, all pointers/count/buffer=0. Outputs: daddr=0, dwdata=0, dwe=0, busy=0, done=0.
- Reset asserted mid-transfer aborts at once: dwe drops to 0 asynchronously, no further writes, no done pulse.
- IDLE:
  - busy=0, dwe=0, daddr=0, dwdata=0.
  - On start=1 with len_words!=0: latch all inputs; go to WRITE if mode=0, READ if mode=1.
  - On start=1 with len_words=0: go to DONE with no bus activity.
- READ (copy only):
  - daddr=src ptr, dwe=0, busy=1.
  - At the posedge, buffer<=drdata, src ptr+=4, go to WRITE.
- WRITE:
  - daddr=dst ptr, dwe=4'hF, busy=1.
  - dwdata = fill pattern (fill) or buffer (copy).
  - At the posedge: dst ptr+=4, count-=1. If the new count is 0, go to DONE; otherwise go to WRITE (fill) or READ (copy).
- DONE: done=1, busy=0, dwe=0 for exactly one cycle, then IDLE.
- Latency, with start sampled at edge t0:
  - Fill N words: writes occupy cycles t0+1..t0+N; done high in cycle t0+N+1.
  - Copy N words: 2N bus cycles; done in cycle t0+2N+1.
- start while not IDLE (including DONE) is ignored; it is not queued.
- Pointers wrap modulo 2^32 (0xFFFFFFFC+4 = 0x00000000).
- Copy order is strictly ascending. An overlapping copy with dst>src therefore replicates data; this is defined behaviour, not an error.
- Input changes after start has no effect on an in-flight transfer.

Optional Feature:
- Macro: DBUS_DMA_CHECKSUM_EN.
- When defined:
  - Extra output port checksum (out, 32).
  - checksum clears to 0 on reset and on each accepted start.
  - It adds each word written (dwdata in WRITE cycles), modulo 2^32, and is stable from the DONE cycle until the next start.
- When undefined: the port and its logic are absent; the rest of the behaviour is identical.

Test Plan:
- Fill: reset 100ns; start, mode=0, dst=0x40, len=4, fill=0xDEADBEEF.
  - dmem words 16..19 = 0xDEADBEEF; words 15 and 20 unchanged.
  - busy high for 4 cycles; done pulses once, 5 cycles after the start edge.
- Copy: preload words 0..3 = 1,2,3,4; start, mode=1, src=0x0, dst=0x100, len=4.
  - Words 64..67 = 1,2,3,4.
  - dwe=F only in alternate cycles; done at t0+9.
- Zero length: start with len=0.
  - No cycle with dwe!=0; done pulse one cycle after start; busy never asserts.
- Start ignored: pulse start again mid-fill with dst=0x200.
  - Region at 0x200 untouched; exactly one done pulse.
- Reset abort: assert reset after the 2nd write of a len=8 fill at 0x80.
  - Only words 32..33 written; dwe=0 in the same cycle reset rises.
  - done never pulses; busy=0 after reset.
- With DBUS_DMA_CHECKSUM_EN: fill len=3, fill=0x80000001.
  - checksum = 0x80000003 in the DONE cycle.
